bno055_i2c_target: RTL and testbench
====================================

# bno055_i2c_target

I2C target (responder) that emulates the BNO055 register interface seen by our I2C read/write initiator. It decodes START/STOP, matches a 7-bit device address, and accepts a register pointer followed by write data or read bursts. Reads return CHIP_ID, OPR_MODE and snapshotted Euler data from input ports. It sits on the SDA/SCL pair in place of the physical sensor, for simulation and on-board loopback of the attitude-indicator pipeline without hardware.

## Interface
- DEV_ADDR, 7'h28: 7-bit I2C address acknowledged.
- CHIP_ID, 8'hA0: value returned at register 0x00.
- i_clk  in  1  system clock (25 MHz on Go Board).
- i_rst_n  in  1  reset; asynchronous and active-low.
- i_scl  in  1  SCL line level (asynchronous, open-drain bus).
- i_sda  in  1  SDA line level (asynchronous).
- o_sda_oe  out  1  1 = pull SDA low; 0 = release.
- i_heading  in  16  EUL_DATA_X source.
- i_roll  in  16  EUL_DATA_Y source.
- i_pitch  in  16  EUL_DATA_Z source.
- o_opr_mode  out  4  current OPR_MODE[3:0].
- o_busy  out  1  high from matched address ACK until STOP/START/NACK-release.
- o_wr_pulse  out  1  one-cycle pulse per accepted data-byte write.

## Operation
- Input conditioning: i_scl, i_sda each through 2-flop synchronizer plus a history flop; edges are detected on synchronized values.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both are recognized in every state; START (incl. repeated) enters ADDR with bit count 0; STOP enters IDLE. Either releases o_sda_oe the same cycle.
- Data bits sampled on SCL rising edge, MSB first; o_sda_oe changes only on SCL falling edge (except START/STOP/reset release).
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT.
- ADDR: shift 8 bits. On the 8th falling edge: if addr[7:1]==DEV_ADDR, drive ACK (ADDR_ACK); otherwise WAIT (no ACK, ignore until START/STOP).
- ADDR_ACK: release on the next SCL falling edge. R/W=0 -> PTR. R/W=1 -> capture Euler snapshot and go to RDATA, driving bit 7 of reg[pointer] on that same falling edge.
- PTR: 8 bits loaded into pointer; ACK; then WDATA.
- WDATA: 8 bits; ACK; write reg[pointer]; o_wr_pulse high for one cycle at the ACK falling edge; pointer+1; stay in WDATA for further bytes.
- RDATA: o_sda_oe = ~bit; after the 8th bit falling edge release for RACK. RACK samples the master bit at SCL rise. ACK (0): pointer+1, load next byte, drive MSB on the next fall. NACK (1): WAIT.
- Register map (8-bit pointer, wraps 0xFF->0x00):
  - 0x00 CHIP_ID (RO).
  - 0x1A/0x1B heading LSB/MSB; 0x1C/0x1D roll; 0x1E/0x1F pitch (RO, from snapshot).
  - 0x3D OPR_MODE: write stores data[3:0]; read returns {4'h0, mode}.
  - All others read 0x00; writes are ignored but still ACKed and still pulse o_wr_pulse.
- Snapshot: all 48 Euler bits latched together at the read-address ACK. A burst is coherent even if inputs change mid-burst.

## Timing
- Reset (async assert, sync-released use): o_sda_oe=0, o_opr_mode=0, o_busy=0, o_wr_pulse=0, state IDLE, pointer 0x00, snapshot 0.
- Edge detect latency: 3 i_clk cycles from line change to internal event. Requires i_clk >= 16x SCL; 25 MHz supports 400 kHz.
- ACK/data drive is asserted 3 cycles after the SCL fall, well inside tLOW.
- o_busy rises with ADDR_ACK drive and falls on STOP, START, or entry to WAIT.
- Reset mid-transaction: SDA released immediately; the bus stays idle until a new START.

## Test plan
- Write 0x50 (addr 0x28 W), 0x00, Sr, 0x51, read 1 byte + NACK -> every ACK low, byte 0xA0, SDA released after NACK, o_busy low after STOP.
- Write 0x50, 0x3D, 0x0B, STOP -> o_opr_mode=4'hB, one o_wr_pulse; read back at 0x3D -> 0x0B.
- i_roll=16'h1234, i_pitch=16'hFF9C; pointer 0x1C, burst read 4 with ACK,ACK,ACK,NACK -> bytes 34,12,9C,FF. Change i_pitch after byte 1 -> still 9C,FF.
- Address 0x29 (byte 0x52) -> no ACK, o_sda_oe stays 0, o_opr_mode unchanged, next valid transaction succeeds.
- Pointer 0xFF, burst read 2 -> bytes 0x00 (reg FF), 0xA0 (wrap to 0x00).
- Assert i_rst_n low while driving a read data bit 0 -> o_sda_oe=0 asynchronously, o_opr_mode=0; the subsequent full transaction works.

Source files
------------

// File: rtl/bno055_i2c_if.sv
// Open-drain I2C bus as seen by the BNO055 emulator: line levels in, SDA pull-down out.
interface bno055_i2c_if;
  logic scl;
  logic sda;
  logic sda_oe;

  modport master (output scl, sda, input sda_oe);
  modport slave  (input scl, sda, output sda_oe);
endinterface

// File: rtl/bno055_i2c_target.sv
// BNO055-compatible I2C target: CHIP_ID, OPR_MODE and a coherent Euler snapshot
// behind an auto-incrementing register pointer.
module bno055_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h28,
  parameter logic [7:0] CHIP_ID  = 8'hA0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  bno055_i2c_if.slave bus,
  input  logic [15:0] i_heading,
  input  logic [15:0] i_roll,
  input  logic [15:0] i_pitch,
  output logic [3:0]  o_opr_mode,
  output logic        o_busy,
  output logic        o_wr_pulse
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT
  } state_t;

  logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall, start, stop, byte_done;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  shift, shift_n, ptr, ptr_n, tx, tx_n, rd;
  logic [47:0] snap, snap_n, live;
  logic [3:0]  mode, mode_n;
  logic        rw, rw_n, oe, oe_n, busy, busy_n, wr, wr_n;

  function automatic logic [7:0] reg_read(input logic [7:0] addr,
                                          input logic [47:0] eul,
                                          input logic [3:0] opr);
    case (addr)
      8'h00:   reg_read = CHIP_ID;
      8'h1A:   reg_read = eul[7:0];
      8'h1B:   reg_read = eul[15:8];
      8'h1C:   reg_read = eul[23:16];
      8'h1D:   reg_read = eul[31:24];
      8'h1E:   reg_read = eul[39:32];
      8'h1F:   reg_read = eul[47:40];
      8'h3D:   reg_read = {4'h0, opr};
      default: reg_read = 8'h00;
    endcase
  endfunction

  // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a true shift chain.
      {scl_s1, scl_s2, scl_h} <= {bus.scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {bus.sda, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start     = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop      = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign byte_done = scl_fall && (cnt == 4'd8);
  assign live      = {i_pitch, i_roll, i_heading};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
      ptr   <= '0;
      tx    <= '0;
      snap  <= '0;
      mode  <= '0;
      rw    <= 1'b0;
      oe    <= 1'b0;
      busy  <= 1'b0;
      wr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shift <= shift_n;
      ptr   <= ptr_n;
      tx    <= tx_n;
      snap  <= snap_n;
      mode  <= mode_n;
      rw    <= rw_n;
      oe    <= oe_n;
      busy  <= busy_n;
      wr    <= wr_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    ptr_n   = ptr;
    tx_n    = tx;
    snap_n  = snap;
    mode_n  = mode;
    rw_n    = rw;
    oe_n    = oe;
    busy_n  = busy;
    wr_n    = 1'b0;
    rd      = 8'h00;

    if (start) begin
      state_n = ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      if ((state == ADDR || state == PTR || state == WDATA) && scl_rise && cnt != 4'd8) begin
        shift_n = {shift[6:0], sda_s2};
        cnt_n   = cnt + 4'd1;
      end
      if (byte_done) cnt_n = '0;

      case (state)
        ADDR: if (byte_done) begin
          if (shift[7:1] == DEV_ADDR) begin
            oe_n    = 1'b1;
            busy_n  = 1'b1;
            rw_n    = shift[0];
            state_n = ADDR_ACK;
          end else begin
            state_n = WAIT;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!rw) begin
            oe_n    = 1'b0;
            state_n = PTR;
          end else begin
            snap_n  = live;
            rd      = reg_read(ptr, live, mode);
            tx_n    = rd;
            oe_n    = ~rd[7];
            cnt_n   = 4'd1;
            state_n = RDATA;
          end
        end
        PTR: if (byte_done) begin
          ptr_n   = shift;
          oe_n    = 1'b1;
          state_n = PTR_ACK;
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          oe_n    = 1'b0;
          state_n = WDATA;
        end
        WDATA: if (byte_done) begin
          if (ptr == 8'h3D) mode_n = shift[3:0];
          wr_n    = 1'b1;
          ptr_n   = ptr + 8'd1;
          oe_n    = 1'b1;
          state_n = WDATA_ACK;
        end
        RDATA: if (scl_fall) begin
          if (cnt == 4'd8) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = RACK;
          end else begin
            oe_n  = ~tx[6];
            tx_n  = {tx[6:0], 1'b0};
            cnt_n = cnt + 4'd1;
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_s2) begin
              state_n = WAIT;
              busy_n  = 1'b0;
            end else begin
              ptr_n = ptr + 8'd1;
              cnt_n = 4'd1;
            end
          end else if (scl_fall && cnt == 4'd1) begin
            rd      = reg_read(ptr, snap, mode);
            tx_n    = rd;
            oe_n    = ~rd[7];
            state_n = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe = oe;
  assign o_opr_mode = mode;
  assign o_busy     = busy;
  assign o_wr_pulse = wr;

endmodule

// File: tb/tb_bno055_i2c_target.sv
// Directed bench: a bit-banged I2C initiator exercising the BNO055 target register map.
module tb_bno055_i2c_target;
  localparam int Q = 20;  // clk cycles per quarter SCL period

  logic        clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  logic [15:0] heading = 16'hABCD, roll = 16'h0000, pitch = 16'h0000;
  logic [3:0]  opr_mode;
  logic        busy, wr_pulse;
  int          n_cmp = 0, n_err = 0, wr_count = 0, oe_count = 0;

  bno055_i2c_if bus();
  assign bus.scl = m_scl;
  assign bus.sda = m_sda & ~bus.sda_oe;

  bno055_i2c_target dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .i_heading(heading), .i_roll(roll), .i_pitch(pitch),
    .o_opr_mode(opr_mode), .o_busy(busy), .o_wr_pulse(wr_pulse)
  );

  always #20 clk = ~clk;
  always @(negedge clk) begin
    if (wr_pulse) wr_count++;
    if (bus.sda_oe) oe_count++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q(); m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q(); m_scl = 1'b1; wait_q(); m_sda = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q(); m_scl = 1'b1; wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q(); m_scl = 1'b1;
    repeat (Q / 2) @(negedge clk);
    b = bus.sda;
    repeat (Q / 2) @(negedge clk);
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", bus.sda_oe); end
    n_cmp++; if (opr_mode !== 4'h0) begin n_err++; $display("FAIL reset_mode: got %h want 0", opr_mode); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (wr_pulse !== 1'b0) begin n_err++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
  endtask

  task automatic test_chip_id();
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start(); write_byte(8'h50, a0); write_byte(8'h00, a1);
    i2c_start(); write_byte(8'h51, a2);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL chip_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL chip_busy_hi: got %b want 1", busy); end
    read_byte(d, 1'b1);
    n_cmp++; if (d !== 8'hA0) begin n_err++; $display("FAIL chip_id: got %h want a0", d); end
    n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL chip_release: got %b want 0", bus.sda_oe); end
    i2c_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL chip_busy_lo: got %b want 0", busy); end
  endtask

  task automatic test_opr_mode();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d;
    int wr0;
    wr0 = wr_count;
    i2c_start(); write_byte(8'h50, a0); write_byte(8'h3D, a1); write_byte(8'h0B, a2); i2c_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL mode_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (opr_mode !== 4'hB) begin n_err++; $display("FAIL mode_value: got %h want b", opr_mode); end
    n_cmp++; if (wr_count - wr0 !== 1) begin n_err++; $display("FAIL mode_wr_pulses: got %0d want 1", wr_count - wr0); end
    i2c_start(); write_byte(8'h50, a3); write_byte(8'h3D, a4);
    i2c_start(); write_byte(8'h51, a5); read_byte(d, 1'b1); i2c_stop();
    n_cmp++; if ({a3, a4, a5, d} !== {3'b000, 8'h0B}) begin n_err++; $display("FAIL mode_readback: got acks %b data %h want 000 0b", {a3, a4, a5}, d); end
  endtask

  task automatic test_euler_burst();
    logic a0, a1, a2;
    logic [7:0] b0, b1, b2, b3;
    roll = 16'h1234; pitch = 16'hFF9C;
    i2c_start(); write_byte(8'h50, a0); write_byte(8'h1C, a1);
    i2c_start(); write_byte(8'h51, a2);
    read_byte(b0, 1'b0);
    pitch = 16'h0000;
    read_byte(b1, 1'b0); read_byte(b2, 1'b0); read_byte(b3, 1'b1); i2c_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL euler_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (b0 !== 8'h34) begin n_err++; $display("FAIL euler_b0: got %h want 34", b0); end
    n_cmp++; if (b1 !== 8'h12) begin n_err++; $display("FAIL euler_b1: got %h want 12", b1); end
    n_cmp++; if (b2 !== 8'h9C) begin n_err++; $display("FAIL euler_b2: got %h want 9c", b2); end
    n_cmp++; if (b3 !== 8'hFF) begin n_err++; $display("FAIL euler_b3: got %h want ff", b3); end
  endtask

  task automatic test_bad_addr();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d;
    int oe0;
    oe0 = oe_count;
    i2c_start(); write_byte(8'h52, a0); write_byte(8'h3D, a1); write_byte(8'h05, a2); i2c_stop();
    n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("FAIL bad_addr_nack: got %b want 1", a0); end
    n_cmp++; if (oe_count !== oe0) begin n_err++; $display("FAIL bad_addr_oe: got %0d drive cycles want 0", oe_count - oe0); end
    n_cmp++; if (opr_mode !== 4'hB) begin n_err++; $display("FAIL bad_addr_mode: got %h want b", opr_mode); end
    i2c_start(); write_byte(8'h50, a3); write_byte(8'h00, a4);
    i2c_start(); write_byte(8'h51, a5); read_byte(d, 1'b1); i2c_stop();
    n_cmp++; if ({a3, a4, a5, d} !== {3'b000, 8'hA0}) begin n_err++; $display("FAIL bad_addr_recover: got acks %b data %h want 000 a0", {a3, a4, a5}, d); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    i2c_start(); write_byte(8'h50, a0); write_byte(8'hFF, a1);
    i2c_start(); write_byte(8'h51, a2); read_byte(b0, 1'b0); read_byte(b1, 1'b1); i2c_stop();
    n_cmp++; if ({a0, a1, a2, b0} !== {3'b000, 8'h00}) begin n_err++; $display("FAIL wrap_ff: got acks %b data %h want 000 00", {a0, a1, a2}, b0); end
    n_cmp++; if (b1 !== 8'hA0) begin n_err++; $display("FAIL wrap_00: got %h want a0", b1); end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2, a3, a4, a5, b;
    logic [7:0] d;
    i2c_start(); write_byte(8'h50, a0); write_byte(8'h00, a1);
    i2c_start(); write_byte(8'h51, a2);
    read_bit(b);  // MSB of 0xA0; target now drives bit 6 = 0
    n_cmp++; if ({a0, a1, a2, b, bus.sda_oe} !== 5'b00011) begin n_err++; $display("FAIL mid_pre: got %b want 00011", {a0, a1, a2, b, bus.sda_oe}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL mid_oe: got %b want 0", bus.sda_oe); end
    n_cmp++; if (opr_mode !== 4'h0) begin n_err++; $display("FAIL mid_mode: got %h want 0", opr_mode); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_q(); i2c_stop();
    i2c_start(); write_byte(8'h50, a3); write_byte(8'h00, a4);
    i2c_start(); write_byte(8'h51, a5); read_byte(d, 1'b1); i2c_stop();
    n_cmp++; if ({a3, a4, a5, d} !== {3'b000, 8'hA0}) begin n_err++; $display("FAIL mid_recover: got acks %b data %h want 000 a0", {a3, a4, a5}, d); end
  endtask

  initial begin
    test_reset();
    test_chip_id();
    test_opr_mode();
    test_euler_burst();
    test_bad_addr();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
